forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl.sv | 127 ++++++++++++
 tb/tb_forward_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
// Operand forwarding and load-use hazard control for the 5-stage pipeline.
// Optional macro FWD_STALL_CNT_EN adds a saturating load-use stall counter.
module forward_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [2:0] id_sr1,
    input  logic       id_sr1_used,
    input  logic [2:0] id_sr2,
    input  logic       id_sr2_used,
    input  logic [2:0] id_dr,
    input  logic       id_dr_we,
    input  logic       id_is_load,
    input  logic       stall_in,
    input  logic       flush,
    output logic [2:0] a_sel,
    output logic [2:0] b_sel,
    output logic       load_use_stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       valid;
        logic [2:0] dr;
        logic       we;
        logic       ld;
    } ent_t;

    localparam ent_t BUBBLE = '0;

    ent_t ex_q, ex_d;
    ent_t mem_q, mem_d;
    ent_t wb_q, wb_d;
    logic lu_a, lu_b;

    function automatic logic hit(input ent_t e, input logic [2:0] r,
                                 input logic used, input logic vld);
        return e.valid && e.we && (e.dr == r) && used && vld;
    endfunction

    // SR1 select: youngest match wins; a load in EX stalls instead
    always_comb begin
        a_sel = 3'b000;
        lu_a  = 1'b0;
        if (hit(ex_q, id_sr1, id_sr1_used, id_valid)) begin
            if (ex_q.ld) lu_a = 1'b1;
            else         a_sel = 3'b100;
        end else if (hit(mem_q, id_sr1, id_sr1_used, id_valid)) begin
            a_sel = 3'b010;
        end else if (hit(wb_q, id_sr1, id_sr1_used, id_valid)) begin
            a_sel = 3'b001;
        end
    end

    // SR2 select: same priority as SR1
    always_comb begin
        b_sel = 3'b000;
        lu_b  = 1'b0;
        if (hit(ex_q, id_sr2, id_sr2_used, id_valid)) begin
            if (ex_q.ld) lu_b = 1'b1;
            else         b_sel = 3'b100;
        end else if (hit(mem_q, id_sr2, id_sr2_used, id_valid)) begin
            b_sel = 3'b010;
        end else if (hit(wb_q, id_sr2, id_sr2_used, id_valid)) begin
            b_sel = 3'b001;
        end
    end

    assign load_use_stall = (lu_a || lu_b) && !flush;

    // History advance: hold on stall, bubble on load-use or flush
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall_in) begin
            if (id_valid && !load_use_stall && !flush) begin
                ex_d.valid = 1'b1;
                ex_d.dr    = id_dr;
                ex_d.we    = id_dr_we;
                ex_d.ld    = id_is_load;
            end else begin
                ex_d = BUBBLE;
            end
            mem_d = flush ? BUBBLE : ex_q;
            wb_d  = mem_q;
        end
    end

    // History registers with synchronous reset overriding stall and flush
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Count edges where a load-use bubble is actually inserted; saturate
    always_comb begin
        cnt_d = cnt_q;
        if (load_use_stall && !stall_in && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed self-checking bench for forward_ctrl.
// Counter checks are built only when FWD_STALL_CNT_EN is defined.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_sr1;
    logic       id_sr1_used;
    logic [2:0] id_sr2;
    logic       id_sr2_used;
    logic [2:0] id_dr;
    logic       id_dr_we;
    logic       id_is_load;
    logic       stall_in;
    logic       flush;
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic       load_use_stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    forward_ctrl #(.CNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_sr1         (id_sr1),
        .id_sr1_used    (id_sr1_used),
        .id_sr2         (id_sr2),
        .id_sr2_used    (id_sr2_used),
        .id_dr          (id_dr),
        .id_dr_we       (id_dr_we),
        .id_is_load     (id_is_load),
        .stall_in       (stall_in),
        .flush          (flush),
        .a_sel          (a_sel),
        .b_sel          (b_sel),
        .load_use_stall (load_use_stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a decode-stage instruction then let combinational outputs settle
    task automatic id(input logic v, input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2,
                      input logic [2:0] d, input logic we, input logic ld);
        id_valid    = v;
        id_sr1      = s1;
        id_sr1_used = u1;
        id_sr2      = s2;
        id_sr2_used = u2;
        id_dr       = d;
        id_dr_we    = we;
        id_is_load  = ld;
        #1;
    endtask

    task automatic nop();
        id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset    = 1'b1;
        stall_in = 1'b0;
        flush    = 1'b0;
        nop();
        tick();
        tick();
        reset = 1'b0;

        // Reset state: nothing valid, even reading R0 with use flags set
        id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        check("rst_a", a_sel, 3'b000);
        check("rst_b", b_sel, 3'b000);
        check("rst_lus", load_use_stall, 1'b0);
`ifdef FWD_STALL_CNT_EN
        check("rst_cnt", stall_cnt, 16'd0);
`endif
        drain();

        // ADD R3 ; ADD R1,R3,R3 -> EX forward on both operands
        id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
        check("ex_fwd_a", a_sel, 3'b100);
        check("ex_fwd_b", b_sel, 3'b100);
        check("ex_fwd_lus", load_use_stall, 1'b0);
        // Same history but ID invalid -> no forward
        id(1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
        check("idv_gate_a", a_sel, 3'b000);
        drain();

        // LDR R2 ; ADD R4,R2,R5 -> one stall cycle, then MEM forward
        id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        id(1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0);
        check("lu_stall", load_use_stall, 1'b1);
        check("lu_a", a_sel, 3'b000);
        check("lu_b", b_sel, 3'b000);
        tick();
        check("lu_release", load_use_stall, 1'b0);
        check("lu_mem_a", a_sel, 3'b010);
        drain();

        // ADD R6 ; NOP ; NOP ; use R6 -> WB forward, then none
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        tick();
        id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("wb_fwd_a", a_sel, 3'b001);
        tick();
        check("wb_aged_a", a_sel, 3'b000);
        drain();

        // R3 in EX and WB read as SR2 -> EX wins; next cycle MEM only
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
        check("young_b", b_sel, 3'b100);
        check("young_a", a_sel, 3'b000);
        tick();
        check("mem_over_wb_b", b_sel, 3'b010);
        drain();

        // R0 and R7 are forwardable; unused operand is not
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
        check("r0_a", a_sel, 3'b100);
        check("r0_unused_b", b_sel, 3'b000);
        tick();
        id(1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0);
        check("r7_b", b_sel, 3'b100);
        check("r7_unused_a", a_sel, 3'b000);
        drain();

        // Flush kills ADD R3 in ID and in EX
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("flush_a0", a_sel, 3'b000);
        tick();
        check("flush_a1", a_sel, 3'b000);
        drain();

        // Flush masks load-use stall
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        id(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_lus", load_use_stall, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_lus_after", load_use_stall, 1'b0);
        check("flush_b_after", b_sel, 3'b000);
        drain();

        // LDR R2 in EX frozen by 5-cycle stall_in, flush ignored meanwhile
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        stall_in = 1'b1;
        #1;
        check("stl_lus0", load_use_stall, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tick();
        tick();
        check("stl_lus5", load_use_stall, 1'b1);
        check("stl_a5", a_sel, 3'b000);
`ifdef FWD_STALL_CNT_EN
        check("stl_cnt_hold", stall_cnt, 16'd1);
`endif
        stall_in = 1'b0;
        #1;
        tick();
        check("stl_rel_lus", load_use_stall, 1'b0);
        check("stl_rel_a", a_sel, 3'b010);
`ifdef FWD_STALL_CNT_EN
        check("stl_cnt_inc", stall_cnt, 16'd2);
`endif
        drain();

        // Reset during stall clears the pending load match
        id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
        stall_in = 1'b1;
        reset    = 1'b1;
        #1;
        check("rs_pre_lus", load_use_stall, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        check("rs_lus", load_use_stall, 1'b0);
        check("rs_a", a_sel, 3'b000);
        stall_in = 1'b0;
        #1;
        tick();
        check("rs_rel_b", b_sel, 3'b000);
`ifdef FWD_STALL_CNT_EN
        check("rs_cnt", stall_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
